// File: rtl/ip_tx_arbiter.sv
// ip_tx_arbiter
//   Shares one IP header generator among NUM_REQ requesters. For each packet, a
//   round-robin grant is chosen in IDLE. The granted length beat is forwarded to
//   the header generator, and the generated header bytes are passed through to
//   the output. The granted requester's payload bytes follow on the same output.
//   One IDLE cycle separates consecutive packets.
//
// Ports
//   clk, sresetn                  clock, asynchronous active-low reset
//   req_len_*  (per requester)    payload-length beat (one beat per packet)
//   req_protocol, req_dest_ip     per-requester header fields
//   pay_i_*    (per requester)    byte-wide payload stream
//   hdr_len_*                     length stream towards the header generator
//   hdr_protocol, hdr_dest_ip     registered header fields of the granted requester
//   hdr_i_*                       header bytes from the header generator
//   axis_o_*                      framed packet output (header, then payload)
module ip_tx_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                    clk,
    input  logic                    sresetn,
    output logic [NUM_REQ-1:0]      req_len_tready,
    input  logic [NUM_REQ-1:0]      req_len_tvalid,
    input  logic [NUM_REQ-1:0]      req_len_tlast,
    input  logic [16*NUM_REQ-1:0]   req_len_tdata,
    input  logic [8*NUM_REQ-1:0]    req_protocol,
    input  logic [32*NUM_REQ-1:0]   req_dest_ip,
    output logic [NUM_REQ-1:0]      pay_i_tready,
    input  logic [NUM_REQ-1:0]      pay_i_tvalid,
    input  logic [NUM_REQ-1:0]      pay_i_tlast,
    input  logic [8*NUM_REQ-1:0]    pay_i_tdata,
    input  logic                    hdr_len_tready,
    output logic                    hdr_len_tvalid,
    output logic                    hdr_len_tlast,
    output logic [15:0]             hdr_len_tdata,
    output logic [7:0]              hdr_protocol,
    output logic [31:0]             hdr_dest_ip,
    output logic                    hdr_i_tready,
    input  logic                    hdr_i_tvalid,
    input  logic                    hdr_i_tlast,
    input  logic [7:0]              hdr_i_tdata,
    input  logic                    axis_o_tready,
    output logic                    axis_o_tvalid,
    output logic                    axis_o_tlast,
    output logic [7:0]              axis_o_tdata
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, LEN, HDR, PAY} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic [7:0]      hdr_protocol_q, hdr_protocol_d;
    logic [31:0]     hdr_dest_ip_q, hdr_dest_ip_d;

    // Per-requester views of the flattened buses
    logic [15:0]     len_arr   [NUM_REQ];
    logic [7:0]      proto_arr [NUM_REQ];
    logic [31:0]     dest_arr  [NUM_REQ];
    logic [7:0]      pay_arr   [NUM_REQ];

    // The length stream is single-beat by construction, so its tlast carries no information.
    logic            unused_len_tlast;
    assign unused_len_tlast = ^req_len_tlast;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign len_arr[gi]   = req_len_tdata[16*gi +: 16];
            assign proto_arr[gi] = req_protocol[8*gi +: 8];
            assign dest_arr[gi]  = req_dest_ip[32*gi +: 32];
            assign pay_arr[gi]   = pay_i_tdata[8*gi +: 8];
            assign req_len_tready[gi] = (state_q == LEN) && (grant_q == GW'(gi)) && hdr_len_tready;
            assign pay_i_tready[gi]   = (state_q == PAY) && (grant_q == GW'(gi)) && axis_o_tready;
        end
    endgenerate

    // Round-robin search starting one past the last completed grant.
    // last_grant + k never reaches 2*NUM_REQ, so a single wrap subtraction suffices.
    logic            arb_found;
    logic [GW-1:0]   arb_idx;
    logic [GW:0]     cand;

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = last_grant_q;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_grant_q} + (GW+1)'(k);
            if (cand >= (GW+1)'(NUM_REQ)) begin
                cand = cand - (GW+1)'(NUM_REQ);
            end
            if (!arb_found && req_len_tvalid[cand[GW-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[GW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            state_q        <= IDLE;
            grant_q        <= '0;
            last_grant_q   <= GW'(NUM_REQ - 1);
            hdr_protocol_q <= '0;
            hdr_dest_ip_q  <= '0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            last_grant_q   <= last_grant_d;
            hdr_protocol_q <= hdr_protocol_d;
            hdr_dest_ip_q  <= hdr_dest_ip_d;
        end
    end

    // Next state and pass-through outputs
    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        last_grant_d   = last_grant_q;
        hdr_protocol_d = hdr_protocol_q;
        hdr_dest_ip_d  = hdr_dest_ip_q;
        hdr_len_tvalid = 1'b0;
        hdr_len_tlast  = 1'b0;
        hdr_len_tdata  = '0;
        hdr_i_tready   = 1'b0;
        axis_o_tvalid  = 1'b0;
        axis_o_tlast   = 1'b0;
        axis_o_tdata   = '0;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    grant_d        = arb_idx;
                    hdr_protocol_d = proto_arr[arb_idx];
                    hdr_dest_ip_d  = dest_arr[arb_idx];
                    state_d        = LEN;
                end
            end
            LEN: begin
                hdr_len_tvalid = 1'b1;
                hdr_len_tlast  = 1'b1;
                hdr_len_tdata  = len_arr[grant_q];
                if (hdr_len_tready) begin
                    state_d = HDR;
                end
            end
            HDR: begin
                axis_o_tvalid = hdr_i_tvalid;
                axis_o_tdata  = hdr_i_tdata;
                hdr_i_tready  = axis_o_tready;
                if (hdr_i_tvalid && axis_o_tready && hdr_i_tlast) begin
                    state_d = PAY;
                end
            end
            PAY: begin
                axis_o_tvalid = pay_i_tvalid[grant_q];
                axis_o_tlast  = pay_i_tlast[grant_q];
                axis_o_tdata  = pay_arr[grant_q];
                if (pay_i_tvalid[grant_q] && axis_o_tready && pay_i_tlast[grant_q]) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign hdr_protocol = hdr_protocol_q;
    assign hdr_dest_ip  = hdr_dest_ip_q;

endmodule

// File: tb/tb_ip_tx_arbiter.sv
// tb_ip_tx_arbiter
//   Directed bench for ip_tx_arbiter with four requesters. The bench models the
//   requesters and a 20-byte header generator. Expected output bytes and grant
//   order are queued as each request is issued, then popped as the DUT emits them.
module tb_ip_tx_arbiter;

    localparam int NR = 4;

    logic              clk;
    logic              sresetn;
    logic [NR-1:0]     req_len_tready, req_len_tvalid, req_len_tlast;
    logic [16*NR-1:0]  req_len_tdata;
    logic [8*NR-1:0]   req_protocol;
    logic [32*NR-1:0]  req_dest_ip;
    logic [NR-1:0]     pay_i_tready, pay_i_tvalid, pay_i_tlast;
    logic [8*NR-1:0]   pay_i_tdata;
    logic              hdr_len_tready, hdr_len_tvalid, hdr_len_tlast;
    logic [15:0]       hdr_len_tdata;
    logic [7:0]        hdr_protocol;
    logic [31:0]       hdr_dest_ip;
    logic              hdr_i_tready, hdr_i_tvalid, hdr_i_tlast;
    logic [7:0]        hdr_i_tdata;
    logic              axis_o_tready, axis_o_tvalid, axis_o_tlast;
    logic [7:0]        axis_o_tdata;

    ip_tx_arbiter #(.NUM_REQ(NR)) dut (
        .clk(clk), .sresetn(sresetn),
        .req_len_tready(req_len_tready), .req_len_tvalid(req_len_tvalid),
        .req_len_tlast(req_len_tlast), .req_len_tdata(req_len_tdata),
        .req_protocol(req_protocol), .req_dest_ip(req_dest_ip),
        .pay_i_tready(pay_i_tready), .pay_i_tvalid(pay_i_tvalid),
        .pay_i_tlast(pay_i_tlast), .pay_i_tdata(pay_i_tdata),
        .hdr_len_tready(hdr_len_tready), .hdr_len_tvalid(hdr_len_tvalid),
        .hdr_len_tlast(hdr_len_tlast), .hdr_len_tdata(hdr_len_tdata),
        .hdr_protocol(hdr_protocol), .hdr_dest_ip(hdr_dest_ip),
        .hdr_i_tready(hdr_i_tready), .hdr_i_tvalid(hdr_i_tvalid),
        .hdr_i_tlast(hdr_i_tlast), .hdr_i_tdata(hdr_i_tdata),
        .axis_o_tready(axis_o_tready), .axis_o_tvalid(axis_o_tvalid),
        .axis_o_tlast(axis_o_tlast), .axis_o_tdata(axis_o_tdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] len;
        logic [7:0]  pr;
        logic [31:0] ds;
    } req_t;

    req_t        req_q [NR][$];
    logic [8:0]  pay_q [NR][$];
    logic [8:0]  exp_q [$];
    int          exp_grant_q [$];

    int          errors = 0;
    int          checks = 0;

    // Header generator model state
    int          hdr_rem = 0;
    logic [15:0] cap_len;
    logic [7:0]  cap_pr;
    logic [31:0] cap_ds;

    bit          in_hdr = 0;
    bit          in_pay = 0;
    int          cur_g = 0;
    int          bubble = 0;
    bit          pend_b = 0;
    bit          bp_mode = 0;
    bit          tog = 0;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hb(int k, logic [15:0] len, logic [7:0] pr, logic [31:0] ds);
        logic [15:0] tot;
        tot = len + 16'd20;
        case (k)
            0:       return 8'h45;
            2:       return tot[15:8];
            3:       return tot[7:0];
            9:       return pr;
            16:      return ds[31:24];
            17:      return ds[23:16];
            18:      return ds[15:8];
            19:      return ds[7:0];
            default: return 8'(k * 13 + 5);
        endcase
    endfunction

    function automatic logic [7:0] pb(logic [7:0] seed, int j);
        return 8'(int'(seed) + j * 3);
    endfunction

    // Issue a request and queue what the output should carry for it.
    // Calls are made in the order the grants are expected.
    task automatic request(int i, logic [15:0] len, logic [7:0] pr, logic [31:0] ds, logic [7:0] seed);
        req_t r;
        r.len = len; r.pr = pr; r.ds = ds;
        req_q[i].push_back(r);
        exp_grant_q.push_back(i);
        for (int k = 0; k < 20; k++) exp_q.push_back({1'b0, hb(k, len, pr, ds)});
        for (int j = 0; j < int'(len); j++) begin
            pay_q[i].push_back({(j == int'(len) - 1), pb(seed, j)});
            exp_q.push_back({(j == int'(len) - 1), pb(seed, j)});
        end
    endtask

    task automatic drive();
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            req_len_tvalid[i] = (req_q[i].size() > 0);
            if (req_q[i].size() > 0) begin
                req_len_tdata[16*i +: 16] = req_q[i][0].len;
                req_protocol[8*i +: 8]    = req_q[i][0].pr;
                req_dest_ip[32*i +: 32]   = req_q[i][0].ds;
            end
            pay_i_tvalid[i] = (pay_q[i].size() > 0);
            if (pay_q[i].size() > 0) begin
                pay_i_tlast[i]          = pay_q[i][0][8];
                pay_i_tdata[8*i +: 8]   = pay_q[i][0][7:0];
            end
        end
        hdr_i_tvalid   = (hdr_rem > 0);
        hdr_i_tlast    = (hdr_rem == 1);
        hdr_i_tdata    = (hdr_rem > 0) ? hb(20 - hdr_rem, cap_len, cap_pr, cap_ds) : 8'h00;
        hdr_len_tready = (hdr_rem == 0);
        axis_o_tready  = bp_mode ? tog : 1'b1;
        tog = ~tog;
    endtask

    task automatic eval();
        logic [8:0] e;
        #1;
        // Arbitration bubble after each packet
        if (bubble == 1) begin
            check("bubble_hdr_len_vld", hdr_len_tvalid, 0);
            check("bubble_axis_vld", axis_o_tvalid, 0);
            pend_b = |req_len_tvalid;
            bubble = 2;
        end else if (bubble == 2) begin
            if (pend_b) check("len_after_bubble", hdr_len_tvalid, 1);
            bubble = 0;
        end
        if (in_hdr) begin
            check("hdr_vld_pass", axis_o_tvalid, hdr_i_tvalid);
            check("hdr_rdy_track", hdr_i_tready, axis_o_tready);
            check("hdr_tlast_low", axis_o_tlast, 0);
        end
        if (in_pay) begin
            check("pay_rdy_track", pay_i_tready[cur_g], axis_o_tready);
            check("pay_rdy_others", pay_i_tready & ~(NR'(1) << cur_g), 0);
        end else if (|pay_i_tvalid) begin
            check("pay_rdy_idle", pay_i_tready, 0);
        end
        if ((in_hdr || in_pay) && |req_len_tvalid) check("no_preempt", req_len_tready, 0);

        // Output scoreboard
        if (axis_o_tvalid && axis_o_tready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_byte", {axis_o_tlast, axis_o_tdata}, 9'h1ff);
            end else begin
                e = exp_q.pop_front();
                check("out_byte", {axis_o_tlast, axis_o_tdata}, e);
            end
        end
        // Requester and header-generator models follow their own handshakes
        for (int i = 0; i < NR; i++) begin
            if (pay_i_tvalid[i] && pay_i_tready[i]) begin
                e = pay_q[i].pop_front();
                if (e[8]) begin
                    in_pay = 0;
                    bubble = 1;
                    $display("packet complete: requester %0d", i);
                end
            end
        end
        if (hdr_i_tvalid && hdr_i_tready) begin
            hdr_rem--;
            if (hdr_rem == 0) begin
                in_hdr = 0;
                in_pay = 1;
            end
        end
        for (int i = 0; i < NR; i++) begin
            if (req_len_tvalid[i] && req_len_tready[i]) begin
                check("grant", i, (exp_grant_q.size() > 0) ? exp_grant_q.pop_front() : -1);
                check("hdr_len_tdata", hdr_len_tdata, req_q[i][0].len);
                check("hdr_protocol", hdr_protocol, req_q[i][0].pr);
                check("hdr_dest_ip", hdr_dest_ip, req_q[i][0].ds);
                check("hdr_len_tvalid", hdr_len_tvalid, 1);
                check("hdr_len_tlast", hdr_len_tlast, 1);
                void'(req_q[i].pop_front());
                cur_g = i;
            end
        end
        if (hdr_len_tvalid && hdr_len_tready) begin
            cap_len = hdr_len_tdata;
            cap_pr  = hdr_protocol;
            cap_ds  = hdr_dest_ip;
            hdr_rem = 20;
            in_hdr  = 1;
        end
    endtask

    function automatic bit quiet();
        bit q;
        q = (exp_q.size() == 0) && !in_hdr && !in_pay && (bubble == 0) && (hdr_rem == 0);
        for (int i = 0; i < NR; i++) q = q && (req_q[i].size() == 0);
        return q;
    endfunction

    task automatic run_idle(string tag, int budget);
        int n;
        n = 0;
        while (!quiet() && n < budget) begin
            drive();
            eval();
            n++;
        end
        check({tag, "_bytes_left"}, exp_q.size(), 0);
        check({tag, "_grants_left"}, exp_grant_q.size(), 0);
    endtask

    task automatic reset_checks(string tag);
        check({tag, "_req_len_tready"}, req_len_tready, 0);
        check({tag, "_pay_i_tready"}, pay_i_tready, 0);
        check({tag, "_hdr_i_tready"}, hdr_i_tready, 0);
        check({tag, "_hdr_len_tvalid"}, hdr_len_tvalid, 0);
        check({tag, "_hdr_len_tdata"}, hdr_len_tdata, 0);
        check({tag, "_axis_o_tvalid"}, axis_o_tvalid, 0);
        check({tag, "_axis_o_tdata"}, axis_o_tdata, 0);
        check({tag, "_axis_o_tlast"}, axis_o_tlast, 0);
        check({tag, "_hdr_protocol"}, hdr_protocol, 0);
        check({tag, "_hdr_dest_ip"}, hdr_dest_ip, 0);
    endtask

    initial begin
        int n;
        sresetn        = 1'b0;
        req_len_tvalid = '0;
        req_len_tlast  = '1;
        req_len_tdata  = '0;
        req_protocol   = '0;
        req_dest_ip    = '0;
        pay_i_tvalid   = '0;
        pay_i_tlast    = '0;
        pay_i_tdata    = '0;
        hdr_len_tready = 1'b1;
        hdr_i_tvalid   = 1'b0;
        hdr_i_tlast    = 1'b0;
        hdr_i_tdata    = '0;
        axis_o_tready  = 1'b1;

        // Reset state, with a request already waiting
        request(0, 16'd8, 8'h11, 32'hC0A80001, 8'h30);
        drive();
        #1;
        reset_checks("reset");
        @(negedge clk);
        sresetn = 1'b1;

        // Single request: 20 header bytes then 8 payload bytes
        run_idle("single", 200);

        // Backpressure on every other cycle through HDR and PAY
        bp_mode = 1;
        request(1, 16'd5, 8'h06, 32'h0A000002, 8'h70);
        run_idle("backpressure", 300);
        bp_mode = 0;

        // Late request arriving during the current packet's payload
        request(0, 16'd4, 8'h11, 32'h01020304, 8'h10);
        n = 0;
        while (!in_pay && n < 200) begin
            drive();
            eval();
            n++;
        end
        check("late_reach_pay", in_pay, 1);
        request(1, 16'd3, 8'h01, 32'h05060708, 8'h90);
        run_idle("late", 300);

        // Single-byte payload from the highest requester
        request(3, 16'd1, 8'h2F, 32'hDEADBEEF, 8'hA5);
        run_idle("one_byte", 200);

        // Leave last_grant at 0, then start another packet and reset mid-header
        request(0, 16'd6, 8'h11, 32'h0B0B0B0B, 8'h22);
        run_idle("pre_reset", 200);
        request(0, 16'd10, 8'h11, 32'h0C0C0C0C, 8'h44);
        n = 0;
        while (!(in_hdr && hdr_rem == 16) && n < 200) begin
            drive();
            eval();
            n++;
        end
        check("reach_hdr_byte5", hdr_rem, 16);
        drive();
        sresetn = 1'b0;
        #1;
        reset_checks("midhdr_reset");
        $display("reset applied during header byte 5");
        for (int i = 0; i < NR; i++) begin
            req_q[i].delete();
            pay_q[i].delete();
        end
        exp_q.delete();
        exp_grant_q.delete();
        hdr_rem = 0;
        in_hdr  = 0;
        in_pay  = 0;
        bubble  = 0;
        @(negedge clk);
        @(negedge clk);
        sresetn = 1'b1;

        // Contention after reset: requester 0 must win first, then alternate
        request(0, 16'd3, 8'h11, 32'hAA000001, 8'h01);
        request(1, 16'd2, 8'h06, 32'hBB000001, 8'h81);
        request(0, 16'd2, 8'h11, 32'hAA000002, 8'h41);
        request(1, 16'd4, 8'h06, 32'hBB000002, 8'hC1);
        run_idle("contention", 600);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ip_tx_arbiter.md
IP_TX_ARBITER -- requirements
Module: ip_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2, the number of requesters sharing one ip_header_gen (range 2..8).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port sresetn, input, 1; reset is asynchronous and active-low.
REQ-004 The block SHALL have ports req_len_tready/tvalid/tlast, output/input/input, NUM_REQ each, carrying per-requester payload-length handshake (one beat per packet).
REQ-005 The block SHALL have port req_len_tdata, input, 16*NUM_REQ, the payload length in bytes; requester i occupies bits [16i+15:16i].
REQ-006 The block SHALL have ports req_protocol (input, 8*NUM_REQ) and req_dest_ip (input, 32*NUM_REQ), per-requester header fields, stable from req_len_tvalid until that requester's payload tlast.
REQ-007 The block SHALL have ports pay_i_tready/tvalid/tlast, output/input/input, NUM_REQ each, and pay_i_tdata, input, 8*NUM_REQ, carrying per-requester byte-wide payload.
REQ-008 The block SHALL have ports hdr_len_tready/tvalid/tlast/tdata[15:0] (input/output/output/output), driving the header generator's payload_length stream.
REQ-009 The block SHALL have ports hdr_protocol, output, 8, and hdr_dest_ip, output, 32, feeding the header generator.
REQ-010 The block SHALL have ports hdr_i_tready/tvalid/tlast/tdata[7:0] (output/input/input/input), carrying the generated header bytes.
REQ-011 The block SHALL have ports axis_o_tready/tvalid/tlast/tdata[7:0] (input/output/output/output), the framed packet output.

Function
REQ-012 The FSM SHALL have states IDLE, LEN, HDR, PAY.
REQ-013 IDLE: when any req_len_tvalid is high, the block SHALL register grant = first requester with tvalid searching from (last_grant+1) mod NUM_REQ upward with wrap, then enter LEN the next cycle.
REQ-014 In IDLE no requester is granted: all req_len_tready, pay_i_tready, hdr_i_tready, hdr_len_tvalid and axis_o_tvalid SHALL be 0.
REQ-015 hdr_protocol and hdr_dest_ip SHALL be registered from the granted requester's fields at grant and held until return to IDLE.
REQ-016 LEN: hdr_len_tvalid=1, hdr_len_tlast=1, hdr_len_tdata=granted req_len_tdata; req_len_tready[grant]=hdr_len_tready combinationally, all others 0; on handshake the FSM SHALL enter HDR.
REQ-017 HDR: axis_o_tvalid/tdata SHALL mirror hdr_i_tvalid/tdata, hdr_i_tready=axis_o_tready, axis_o_tlast=0; on the handshake with hdr_i_tlast=1 the FSM SHALL enter PAY.
REQ-018 PAY: axis_o SHALL mirror pay_i[grant] including tlast, pay_i_tready[grant]=axis_o_tready, all others 0; on the handshake with tlast=1 the FSM SHALL set last_grant=grant and enter IDLE.
REQ-019 Outputs in LEN/HDR/PAY SHALL be combinational pass-through (zero added latency); one IDLE cycle (arbitration bubble) SHALL separate packets.
REQ-020 A requester deasserting req_len_tvalid in IDLE before grant SHALL lose no data; grant is decided only from tvalid sampled in IDLE.
REQ-021 Requests arriving while the FSM is not IDLE SHALL wait; the current packet SHALL never be pre-empted.
REQ-022 hdr_i bytes arriving outside HDR SHALL be back-pressured (hdr_i_tready=0), never dropped.
REQ-023 The block SHALL NOT inspect or check payload byte count against length; a payload of one byte (tlast on first beat) SHALL be handled.

Reset
REQ-024 While sresetn=0: state=IDLE, last_grant=NUM_REQ-1 (requester 0 wins first), hdr_protocol=0, hdr_dest_ip=0, all tvalid/tready outputs=0, hdr_len_tdata=0, axis_o_tdata=0, axis_o_tlast=0.
REQ-025 Reset asserted mid-packet SHALL abort immediately to IDLE; the partially sent packet is not resumed.

Verification
REQ-026 Single request: req 0 len=8, protocol=0x11, dest=0xC0A80001 -> hdr_len_tdata=8, hdr_protocol=0x11, output = 20 header bytes then 8 payload bytes, tlast only on byte 28.
REQ-027 Contention: req 0 and req 1 valid together continuously after reset -> grants 0,1,0,1; each packet contiguous, one bubble between.
REQ-028 Backpressure: axis_o_tready toggled 1,0,1,0 in HDR and PAY -> no byte lost/duplicated; hdr_i_tready and pay_i_tready track axis_o_tready exactly.
REQ-029 Late request: req 1 asserts during req 0's PAY -> req 1 granted on the IDLE cycle after req 0's tlast; req_len_tready[1] stays 0 until LEN.
REQ-030 Reset mid-HDR: sresetn low during byte 5 of header -> all outputs 0 immediately; after release, req 0 granted first.
REQ-031 Single-byte payload with NUM_REQ=4, only req 3 valid -> granted, output 21 bytes, tlast on byte 21.
